// File: rtl/vortex_launch_pkg.sv
// Shared types and default constants for the Vortex launch controller.
//   launch_state_e : 3-bit FSM state encoding, also driven out on the debug
//                    'state' port of vortex_launch_ctrl.
//   err_code_e     : 2-bit failure cause reported on 'err_code'.
//   DEF_*          : default values for the controller parameters.
package vortex_launch_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } launch_state_e;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_START_TIMEOUT = 2'd1,
    ERR_ABORT         = 2'd2,
    ERR_WATCHDOG      = 2'd3
  } err_code_e;

  localparam int unsigned DEF_RESET_CYCLES  = 8;
  localparam int unsigned DEF_START_TIMEOUT = 1024;
  localparam logic [31:0] DEF_WDT_CYCLES    = 32'hFFFF_FFFE;

endpackage

// File: rtl/vortex_launch_cnt.sv
// Loadable saturating up-counter with a terminal-count flag. One instance
// each serves as the reset-hold, start-wait and run-cycle counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears the count)
//   load       : load load_val this cycle (wins over inc)
//   load_val   : value to load
//   inc        : increment by one; the count sticks at all-ones
//   limit      : terminal-count compare value
//   count      : current count
//   tc         : high while count == limit
module vortex_launch_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == limit);

endmodule

// File: rtl/vortex_launch_ctrl.sv
// Vortex launch controller: holds the core in reset for RESET_CYCLES after a
// launch request, waits (bounded by START_TIMEOUT) for the core to report
// busy, then counts run cycles until busy falls. Completion or failure is
// reported through sticky done/err/err_code and a one-cycle irq pulse.
// Optional build macro: VORTEX_LAUNCH_WATCHDOG_EN adds a run watchdog that
// fails the launch with err_code=3 when run_cycles reaches WDT_CYCLES.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start_req   : one-cycle launch pulse (accepted only in IDLE, abort low)
//   abort       : level; terminates an active launch with err_code=2
//   vx_busy     : core busy status
//   vx_reset    : core reset, high except in WAIT_BUSY and RUN
//   done, err   : sticky status of the last launch
//   err_code    : failure cause (0 none, 1 start timeout, 2 abort, 3 watchdog)
//   irq         : one-cycle pulse on the DONE or ERR cycle
//   run_cycles  : cycles spent in RUN for the current or last launch
//   state       : FSM state encoding for debug readback
// Handshake: start_req is a single-cycle request with no acknowledge; a
// request that arrives outside IDLE (or together with abort) is dropped.
module vortex_launch_ctrl
  import vortex_launch_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
  parameter logic [31:0] WDT_CYCLES    = DEF_WDT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  input  logic        abort,
  input  logic        vx_busy,
  output logic        vx_reset,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        irq,
  output logic [31:0] run_cycles,
  output logic [2:0]  state
);

  // Terminal counts sit one below the cycle budgets: the counter holds k-1
  // during the k-th cycle of a state, so tc marks that state's last cycle.
  localparam logic [7:0]  HOLD_LIMIT = 8'(RESET_CYCLES - 1);
  localparam logic [31:0] WAIT_LIMIT = 32'(START_TIMEOUT - 1);
`ifdef VORTEX_LAUNCH_WATCHDOG_EN
  localparam logic [31:0] RUN_LIMIT  = WDT_CYCLES - 32'd1;
`else
  // Without the watchdog, run tc only marks saturation.
  localparam logic [31:0] RUN_LIMIT  = '1;
`endif

  launch_state_e state_q, state_d;
  err_code_e     err_code_q, err_code_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          irq_q, irq_d;

  logic        hold_load, hold_inc, hold_tc;
  logic        wait_load, wait_inc, wait_tc;
  logic        run_load, run_inc, run_tc;
  logic [7:0]  hold_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] run_cnt;

  vortex_launch_cnt #(.W(8)) u_hold_cnt (
    .clk(clk), .reset(reset), .load(hold_load), .load_val(8'd0),
    .inc(hold_inc), .limit(HOLD_LIMIT), .count(hold_cnt), .tc(hold_tc)
  );

  vortex_launch_cnt #(.W(32)) u_wait_cnt (
    .clk(clk), .reset(reset), .load(wait_load), .load_val(32'd0),
    .inc(wait_inc), .limit(WAIT_LIMIT), .count(wait_cnt), .tc(wait_tc)
  );

  vortex_launch_cnt #(.W(32)) u_run_cnt (
    .clk(clk), .reset(reset), .load(run_load), .load_val(32'd0),
    .inc(run_inc), .limit(RUN_LIMIT), .count(run_cnt), .tc(run_tc)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    irq_d      = 1'b0;
    hold_load  = 1'b0;
    hold_inc   = 1'b0;
    wait_load  = 1'b0;
    wait_inc   = 1'b0;
    run_load   = 1'b0;
    run_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        hold_load = 1'b1;
        wait_load = 1'b1;
        // Status stays readable in IDLE until a launch is actually accepted.
        if (start_req && !abort) begin
          state_d    = S_RST_HOLD;
          run_load   = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      S_RST_HOLD: begin
        hold_inc = 1'b1;
        if (abort) begin
          state_d    = S_ERR;
          err_code_d = ERR_ABORT;
        end else if (hold_tc) begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        wait_inc = !vx_busy;
        if (abort) begin
          state_d    = S_ERR;
          err_code_d = ERR_ABORT;
        end else if (vx_busy) begin
          state_d = S_RUN;
        end else if (wait_tc) begin
          state_d    = S_ERR;
          err_code_d = ERR_START_TIMEOUT;
        end
      end
      S_RUN: begin
`ifdef VORTEX_LAUNCH_WATCHDOG_EN
        run_inc = 1'b1;
`else
        run_inc = !run_tc;
`endif
        if (abort) begin
          state_d    = S_ERR;
          err_code_d = ERR_ABORT;
        end
`ifdef VORTEX_LAUNCH_WATCHDOG_EN
        else if (run_tc) begin
          state_d    = S_ERR;
          err_code_d = ERR_WATCHDOG;
        end
`endif
        else if (!vx_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE/ERR always return to IDLE, so these fire only on entry.
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      irq_d  = 1'b1;
    end
    if (state_d == S_ERR) begin
      err_d = 1'b1;
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      irq_q      <= irq_d;
    end
  end

  assign vx_reset   = !((state_q == S_WAIT_BUSY) || (state_q == S_RUN));
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign irq        = irq_q;
  assign run_cycles = run_cnt;
  assign state      = state_q;

endmodule

// File: tb/tb_vortex_launch_ctrl.sv
// Directed bench for vortex_launch_ctrl (RESET_CYCLES=8, START_TIMEOUT=16,
// WDT_CYCLES=100). Each launch pushes its expected completion record
// {done, err, err_code, run_cycles} into exp_q; a monitor pops and compares
// on every irq pulse. Inputs are driven and outputs sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_vortex_launch_ctrl;
  import vortex_launch_pkg::*;

  localparam int W = 36;

  logic        clk = 1'b0;
  logic        reset, start_req, abort, vx_busy;
  logic        vx_reset, done, err, irq;
  logic [1:0]  err_code;
  logic [31:0] run_cycles;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int irq_count = 0;
  int irq_base;
  logic prev_irq = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  vortex_launch_ctrl #(
    .RESET_CYCLES(8), .START_TIMEOUT(16), .WDT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .abort(abort),
    .vx_busy(vx_busy), .vx_reset(vx_reset), .done(done), .err(err),
    .err_code(err_code), .irq(irq), .run_cycles(run_cycles), .state(state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic d, input logic e,
                                       input logic [1:0] c,
                                       input logic [31:0] r);
    return {d, e, c, r};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_vx_reset"}, vx_reset, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'd0);
    check({tag, "_irq"}, irq, 1'b0);
    check({tag, "_run_cycles"}, run_cycles, 32'd0);
  endtask

  // Pulse start_req from IDLE and follow the launch into WAIT_BUSY.
  task automatic launch_to_wait();
    int   n;
    logic rst_ok;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("start_accept", state, S_RST_HOLD);
    n = 0;
    rst_ok = 1'b1;
    while (state == S_RST_HOLD && n < 64) begin
      rst_ok &= vx_reset;
      n++;
      step();
    end
    check("hold_cycles", n, 8);
    check("hold_vx_reset", rst_ok, 1'b1);
    check("enter_wait", state, S_WAIT_BUSY);
    check("wait_vx_reset", vx_reset, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (irq) begin
      irq_count++;
      check("irq_single_cycle", prev_irq, 1'b0);
      check("irq_vx_reset", vx_reset, 1'b1);
      got = {done, err, err_code, run_cycles};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL irq_unexpected: got 0x%0h expected no irq", got);
      end else begin
        exp = exp_q.pop_front();
        check("irq_result", got, exp);
      end
    end
    prev_irq = irq;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; start_req = 1'b0; abort = 1'b0; vx_busy = 1'b0;
    step(3);
    check_reset_outputs("por");
    reset = 1'b0;
    step(6);

    // Normal launch: busy rises after 3 wait cycles, stays high 50 cycles.
    irq_base = irq_count;
    exp_q.push_back(rec(1'b1, 1'b0, 2'd0, 32'd50));
    launch_to_wait();
    step(3);
    vx_busy = 1'b1;
    step(50);
    check("normal_still_run", state, S_RUN);
    vx_busy = 1'b0;
    step();
    check("normal_done_state", state, S_DONE);
    step();
    check("normal_idle", state, S_IDLE);
    check("normal_done_sticky", done, 1'b1);
    check("normal_err", err, 1'b0);
    check("normal_run_cycles", run_cycles, 32'd50);
    check("normal_irq_count", irq_count - irq_base, 1);

    // Start timeout: busy never rises.
    irq_base = irq_count;
    exp_q.push_back(rec(1'b0, 1'b1, 2'd1, 32'd0));
    launch_to_wait();
    n = 0;
    while (state == S_WAIT_BUSY && n < 64) begin
      n++;
      step();
    end
    check("timeout_wait_cycles", n, 16);
    check("timeout_err_state", state, S_ERR);
    check("timeout_err_code", err_code, 2'd1);
    check("timeout_vx_reset", vx_reset, 1'b1);
    step();
    check("timeout_idle", state, S_IDLE);
    check("timeout_err_sticky", err, 1'b1);
    check("timeout_irq_count", irq_count - irq_base, 1);

    // Abort in RUN together with busy falling: abort wins.
    irq_base = irq_count;
    exp_q.push_back(rec(1'b0, 1'b1, 2'd2, 32'd5));
    launch_to_wait();
    vx_busy = 1'b1;
    step();
    step(4);
    check("abort_run_live", run_cycles, 32'd4);
    vx_busy = 1'b0;
    abort = 1'b1;
    step();
    check("abort_err_state", state, S_ERR);
    check("abort_err_code", err_code, 2'd2);
    check("abort_done", done, 1'b0);
    abort = 1'b0;
    step();
    check("abort_idle", state, S_IDLE);
    check("abort_irq_count", irq_count - irq_base, 1);

    // start_req during RUN is dropped; abort+start_req in IDLE is blocked.
    irq_base = irq_count;
    exp_q.push_back(rec(1'b1, 1'b0, 2'd0, 32'd6));
    launch_to_wait();
    vx_busy = 1'b1;
    step();
    step(2);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("ign_run_state", state, S_RUN);
    step(2);
    vx_busy = 1'b0;
    step();
    check("ign_done_state", state, S_DONE);
    step(2);
    check("ign_not_queued", state, S_IDLE);
    abort = 1'b1;
    start_req = 1'b1;
    step();
    abort = 1'b0;
    start_req = 1'b0;
    check("ign_abort_start_idle", state, S_IDLE);
    check("ign_done_held", done, 1'b1);
    check("ign_run_held", run_cycles, 32'd6);
    step(3);
    check("ign_still_idle", state, S_IDLE);
    check("ign_irq_count", irq_count - irq_base, 1);

    // Watchdog: busy held high.
    irq_base = irq_count;
`ifdef VORTEX_LAUNCH_WATCHDOG_EN
    exp_q.push_back(rec(1'b0, 1'b1, 2'd3, 32'd100));
    launch_to_wait();
    vx_busy = 1'b1;
    step();
    n = 0;
    while (state == S_RUN && n < 300) begin
      n++;
      step();
    end
    check("wdt_run_cycles_in_run", n, 100);
    check("wdt_err_state", state, S_ERR);
    check("wdt_err_code", err_code, 2'd3);
    check("wdt_run_cycles", run_cycles, 32'd100);
    vx_busy = 1'b0;
    step();
`else
    launch_to_wait();
    vx_busy = 1'b1;
    step();
    step(150);
    check("nowdt_still_run", state, S_RUN);
    check("nowdt_run_cycles", run_cycles, 32'd150);
    exp_q.push_back(rec(1'b1, 1'b0, 2'd0, 32'd151));
    vx_busy = 1'b0;
    step();
    check("nowdt_done_state", state, S_DONE);
    step();
`endif
    check("wdt_idle", state, S_IDLE);
    check("wdt_irq_count", irq_count - irq_base, 1);

    // Reset asserted in WAIT_BUSY: back to IDLE with reset values, no irq.
    irq_base = irq_count;
    launch_to_wait();
    step(2);
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    step(2);
    check("midrst_idle", state, S_IDLE);
    check("midrst_no_irq", irq_count - irq_base, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
